// File: rtl/nibble_serial_adder_if.sv
// rtl/nibble_serial_adder_if.sv - start/ready/done handshake and operand/result bundle for nibble_serial_adder
interface nibble_serial_adder_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         carry_in;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         carry_out;

  modport master (
    output start, a, b, carry_in,
    input  ready, busy, done, sum, carry_out
  );

  modport slave (
    input  start, a, b, carry_in,
    output ready, busy, done, sum, carry_out
  );
endinterface

// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - wide adder that reuses one 4-bit adder, one nibble per clock
module four_bit_full_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  // Purely combinational 4-bit add with carry in/out
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
endmodule

module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  nibble_serial_adder_if.slave  bus
);
  localparam int W    = 4 * NIBBLES;
  localparam int IDXW = $clog2(NIBBLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [W-1:0]      a_q;
  logic [W-1:0]      b_q;
  logic              carry_q;
  logic [IDXW-1:0]   idx_q;
  logic [W-1:0]      sum_q;
  logic              carry_out_q;

  logic [3:0]        nib_a;
  logic [3:0]        nib_b;
  logic [3:0]        add_sum;
  logic              add_cout;
  logic              last_nib;

  logic              ready_o;
  logic              busy_o;
  logic              done_o;

  assign last_nib = (idx_q == IDXW'(NIBBLES - 1));

  // Operand mux: pick the current nibble of each captured operand
  always_comb begin
    nib_a = 4'h0;
    nib_b = 4'h0;
    for (int k = 0; k < NIBBLES; k++) begin
      if (idx_q == IDXW'(k)) begin
        nib_a = a_q[4*k +: 4];
        nib_b = b_q[4*k +: 4];
      end
    end
  end

  four_bit_full_adder u_adder (
    .a    (nib_a),
    .b    (nib_b),
    .cin  (carry_q),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start only matters in IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_ADD;
      S_ADD:   if (last_nib)  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register only
  always_comb begin
    ready_o = 1'b0;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    case (state_q)
      S_IDLE:  ready_o = 1'b1;
      S_ADD:   busy_o  = 1'b1;
      S_DONE: begin
        busy_o = 1'b1;
        done_o = 1'b1;
      end
      default: ready_o = 1'b0;
    endcase
  end

  // Datapath: capture operands on accept, then write one sum nibble per edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      sum_q       <= '0;
      carry_out_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            carry_q <= bus.carry_in;
            idx_q   <= '0;
          end
        end
        S_ADD: begin
          for (int k = 0; k < NIBBLES; k++) begin
            if (idx_q == IDXW'(k)) begin
              sum_q[4*k +: 4] <= add_sum;
            end
          end
          carry_q <= add_cout;
          if (last_nib) begin
            carry_out_q <= add_cout;
          end else begin
            idx_q <= idx_q + IDXW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.ready     = ready_o;
  assign bus.busy      = busy_o;
  assign bus.done      = done_o;
  assign bus.sum       = sum_q;
  assign bus.carry_out = carry_out_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb/tb_nibble_serial_adder.sv - directed self-checking bench for nibble_serial_adder
module tb_nibble_serial_adder;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;

  nibble_serial_adder_if #(.NIBBLES(4)) bus ();

  nibble_serial_adder #(.NIBBLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_cmp++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Waits up to a bounded number of edges for done; returns edges waited
  task automatic wait_done(output int lat);
    lat = 0;
    while (bus.done !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  // Accepts one operation with a one-cycle start pulse and checks its result
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic [15:0] esum, input logic ecout);
    int lat;
    bus.a        = a;
    bus.b        = b;
    bus.carry_in = cin;
    bus.start    = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_done(lat);
    check({tag, "_latency"}, lat, 4);
    check({tag, "_sum"}, bus.sum, esum);
    check({tag, "_cout"}, bus.carry_out, ecout);
    tick();
    check({tag, "_done_drop"}, bus.done, 1'b0);
    check({tag, "_sum_hold"}, bus.sum, esum);
  endtask

  initial begin
    int lat;
    int pulses;
    n_cmp        = 0;
    n_fail       = 0;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    bus.carry_in = 1'b0;

    // Reset
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("rst_ready", bus.ready, 1'b1);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_sum", bus.sum, 16'h0000);
    check("rst_cout", bus.carry_out, 1'b0);

    // Basic add with per-edge latency check
    bus.a        = 16'h1234;
    bus.b        = 16'h1111;
    bus.carry_in = 1'b0;
    bus.start    = 1'b1;
    tick();
    bus.start = 1'b0;
    check("basic_busy_e0", bus.busy, 1'b1);
    check("basic_ready_e0", bus.ready, 1'b0);
    tick();
    tick();
    tick();
    check("basic_done_e3", bus.done, 1'b0);
    tick();
    check("basic_done_e4", bus.done, 1'b1);
    check("basic_busy_e4", bus.busy, 1'b1);
    check("basic_sum", bus.sum, 16'h2345);
    check("basic_cout", bus.carry_out, 1'b0);
    tick();
    check("basic_done_e5", bus.done, 1'b0);
    check("basic_ready_e5", bus.ready, 1'b1);
    check("basic_sum_hold", bus.sum, 16'h2345);
    check("basic_cout_hold", bus.carry_out, 1'b0);

    // Carry ripple and maximum cases
    run_op("ripple", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1);
    run_op("max", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1);
    run_op("msb", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1);
    run_op("mixed", 16'hA5C3, 16'h5A3C, 1'b0, 16'hFFFF, 1'b0);

    // Busy protection, then start held high for back-to-back accepts
    bus.a        = 16'h0001;
    bus.b        = 16'h0002;
    bus.carry_in = 1'b0;
    bus.start    = 1'b1;
    tick();
    bus.a = 16'hAAAA;
    tick();
    bus.a = 16'h0010;
    bus.b = 16'h0020;
    tick();
    tick();
    tick();
    check("busy_done_e4", bus.done, 1'b1);
    check("busy_sum", bus.sum, 16'h0003);
    tick();
    check("hold_ready_e5", bus.ready, 1'b1);
    tick();
    check("hold_ready_e6", bus.ready, 1'b0);
    check("hold_busy_e6", bus.busy, 1'b1);
    bus.start = 1'b0;
    wait_done(lat);
    check("hold_latency", lat, 4);
    check("hold_sum", bus.sum, 16'h0030);
    check("hold_cout", bus.carry_out, 1'b0);
    tick();

    // Reset mid-operation, asserted between clock edges
    bus.a     = 16'h1234;
    bus.b     = 16'h4321;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("midrst_ready", bus.ready, 1'b1);
    check("midrst_busy", bus.busy, 1'b0);
    check("midrst_done", bus.done, 1'b0);
    check("midrst_sum", bus.sum, 16'h0000);
    check("midrst_cout", bus.carry_out, 1'b0);
    tick();
    rst    = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.done === 1'b1) pulses++;
    end
    check("midrst_no_done", pulses, 0);
    run_op("fresh", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Multi-cycle wide adder that computes a 4*NIBBLES-bit sum one nibble per clock, driving a single instance of the team's four_bit_full_adder and registering its nibble sum and carry between cycles. It sits directly upstream of that adder: it sequences operands and carry into it and collects its outputs. Wide additions therefore reuse the proven 4-bit datapath instead of a wide ripple chain. Control is a start/ready/done handshake.

## Interface
- NIBBLES, default 4: number of 4-bit slices; operand width W = 4*NIBBLES; legal range 2..16.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only while ready=1.
- a  input  W  operand A; captured on the accepting edge.
- b  input  W  operand B; captured on the accepting edge.
- carry_in  input  1  carry into nibble 0; captured on the accepting edge.
- ready  output  1  high in IDLE; a start is accepted only then.
- busy  output  1  high in ADD and DONE.
- done  output  1  one-cycle pulse; sum and carry_out are final while it is high.
- sum  output  W  result register.
- carry_out  output  1  carry out of the top nibble.

## Operation
- States: IDLE, ADD, DONE. Reset state is IDLE.
- IDLE:
  - ready=1, busy=0, done=0.
  - On a clock edge with start=1: capture a, b and carry_in into internal operand and carry registers, clear the nibble index to 0, go to ADD.
  - With start=0: stay in IDLE.
- ADD:
  - The adder instance receives nibble[idx] of A, nibble[idx] of B, and the carry register.
  - Each edge: write the adder sum into sum[4*idx+3:4*idx], load the adder carry into the carry register, then increment idx.
  - On the edge where idx = NIBBLES-1: load carry_out from the adder carry and go to DONE instead of incrementing.
- DONE:
  - done=1 and busy=1 for exactly one cycle, then return to IDLE unconditionally.
- start is ignored in ADD and DONE. Operand changes after the accepting edge have no effect.
- Arithmetic:
  - {carry_out, sum} = a + b + carry_in, exactly W+1 bits, unsigned.
  - Overflow shows only in carry_out; no saturation.
- Output holding:
  - sum nibbles above idx keep stale values during ADD; sum is valid only when done=1 and afterwards.
  - sum and carry_out hold their final values through IDLE until the next accepted start.
  - carry_out is not updated during ADD.
- Reset (rst=1, any state, including mid-ADD):
  - Immediately: state IDLE, ready=1, busy=0, done=0, sum=0, carry_out=0, operand, carry and index registers all 0.
  - No done pulse is produced for the aborted operation.

## Timing
- Latency: let E0 be the edge that accepts start. Nibble k is written at edge E(k+1). State becomes DONE at edge E(NIBBLES), so done is high in the cycle between E(NIBBLES) and E(NIBBLES+1).
- ready returns to 1 after edge E(NIBBLES+1). The earliest next accept is edge E(NIBBLES+2).
- Throughput: one operation per NIBBLES+2 cycles. If start is held high continuously, back-to-back operations are accepted at that rate.
- ready, busy and done are decoded from the state register only. No combinational path exists from start, a or b to any output.
- The adder instance is purely combinational. The critical path is the operand mux, then the 4-bit adder, then the sum/carry registers.

## Test plan
All scenarios use NIBBLES=4.
- Reset: assert rst for 2 cycles, then release -> ready=1, busy=0, done=0, sum=16'h0000, carry_out=0. Assert rst again mid-cycle -> outputs clear without waiting for a clock edge.
- Basic add: a=16'h1234, b=16'h1111, carry_in=0, start pulsed for 1 cycle -> done high exactly 4 edges after the accepting edge, sum=16'h2345, carry_out=0. Values hold after done drops.
- Full carry ripple across nibbles: a=16'hFFFF, b=16'h0000, carry_in=1 -> sum=16'h0000, carry_out=1.
- Maximum: a=16'hFFFF, b=16'hFFFF, carry_in=1 -> sum=16'hFFFF, carry_out=1. Then a=16'h8000, b=16'h8000, carry_in=0 -> sum=16'h0000, carry_out=1.
- Busy protection: accept a=16'h0001, b=16'h0002; pulse start with a=16'hAAAA during ADD -> result is 16'h0003 and the second start is dropped. Then hold start high with a=16'h0010, b=16'h0020 -> the next accept occurs 6 cycles after the first, and its done shows 16'h0030.
- Reset mid-operation: accept a=16'h1234, b=16'h4321; assert rst after 2 edges -> no done pulse, sum=0, carry_out=0. A fresh operation a=16'h00FF, b=16'h0001 then gives sum=16'h0100, carry_out=0.
